// File: rtl/jk_bank_ctrl.sv
// Round-robin command scheduler that pulses j/k on one flop of a JK bank
// and verifies the flop's q afterwards.
module jk_bank_ctrl #(
    parameter int N    = 8,
    parameter int IDXW = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            a_valid,
    output logic            a_ready,
    input  logic [IDXW-1:0] a_idx,
    input  logic [1:0]      a_op,
    input  logic            b_valid,
    output logic            b_ready,
    input  logic [IDXW-1:0] b_idx,
    input  logic [1:0]      b_op,
    output logic [N-1:0]    j,
    output logic [N-1:0]    k,
    input  logic [N-1:0]    q,
    output logic            rsp_valid,
    output logic            rsp_src,
    output logic            rsp_q,
    output logic            rsp_err,
    output logic            busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t          state;
    logic            prio;
    logic            src;
    logic [IDXW-1:0] idx;
    logic            expected;

    logic [IDXW-1:0] sel_idx;
    logic [1:0]      sel_op;
    logic            sel_q;
    logic            sel_in_range;
    logic [N-1:0]    sel_onehot;
    logic            cur_q;
    logic            next_expected;

    always_comb begin
        a_ready = 1'b0;
        b_ready = 1'b0;
        if (rst && state == IDLE) begin
            if (a_valid && (!b_valid || !prio)) begin
                a_ready = 1'b1;
            end else if (b_valid) begin
                b_ready = 1'b1;
            end
        end
    end

    assign sel_idx      = b_ready ? b_idx : a_idx;
    assign sel_op       = b_ready ? b_op  : a_op;
    assign sel_in_range = int'(sel_idx) < N;

    // Index decode bounded by N so out-of-range indices never select a bit.
    always_comb begin
        sel_q      = 1'b0;
        cur_q      = 1'b0;
        sel_onehot = '0;
        for (int i = 0; i < N; i++) begin
            if (int'(sel_idx) == i) begin
                sel_q         = q[i];
                sel_onehot[i] = 1'b1;
            end
            if (int'(idx) == i) begin
                cur_q = q[i];
            end
        end
    end

    always_comb begin
        next_expected = sel_q;
        unique case (sel_op)
            2'b00:   next_expected = sel_q;
            2'b01:   next_expected = 1'b0;
            2'b10:   next_expected = 1'b1;
            default: next_expected = ~sel_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            prio     <= 1'b0;
            src      <= 1'b0;
            idx      <= '0;
            expected <= 1'b0;
            j        <= '0;
            k        <= '0;
        end else begin
            j <= '0;
            k <= '0;
            unique case (state)
                IDLE: begin
                    if (a_ready || b_ready) begin
                        src      <= b_ready;
                        idx      <= sel_idx;
                        expected <= next_expected;
                        prio     <= a_ready;
                        if (sel_in_range) begin
                            state <= DRIVE;
                            j     <= sel_op[1] ? sel_onehot : '0;
                            k     <= sel_op[0] ? sel_onehot : '0;
                        end else begin
                            state <= RESP;
                        end
                    end
                end
                DRIVE:   state <= CHECK;
                CHECK:   state <= IDLE;
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // The flop updates at the end of DRIVE, so the response must see live q.
    assign busy      = (state != IDLE);
    assign rsp_valid = (state == CHECK) || (state == RESP);
    assign rsp_src   = rsp_valid & src;
    assign rsp_q     = (state == CHECK) & cur_q;
    assign rsp_err   = (state == RESP) | ((state == CHECK) & (cur_q != expected));

endmodule

// File: tb/tb_jk_bank_ctrl.sv
// Bench for jk_bank_ctrl: a behavioural JK bank plus a reference model of
// flop contents and arbitration, driven by directed and random commands.
module tb_jk_bank_ctrl;

    localparam int N    = 6;
    localparam int IDXW = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            a_valid = 1'b0;
    logic            a_ready;
    logic [IDXW-1:0] a_idx = '0;
    logic [1:0]      a_op = '0;
    logic            b_valid = 1'b0;
    logic            b_ready;
    logic [IDXW-1:0] b_idx = '0;
    logic [1:0]      b_op = '0;
    logic [N-1:0]    j;
    logic [N-1:0]    k;
    logic [N-1:0]    bank = '0;
    logic            rsp_valid;
    logic            rsp_src;
    logic            rsp_q;
    logic            rsp_err;
    logic            busy;

    logic inject = 1'b0;
    bit   prio_m = 1'b0;
    bit   ref_bank [N];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    jk_bank_ctrl #(.N(N), .IDXW(IDXW)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_idx(a_idx), .a_op(a_op),
        .b_valid(b_valid), .b_ready(b_ready), .b_idx(b_idx), .b_op(b_op),
        .j(j), .k(k), .q(bank),
        .rsp_valid(rsp_valid), .rsp_src(rsp_src), .rsp_q(rsp_q),
        .rsp_err(rsp_err), .busy(busy)
    );

    // Flop bank; inject makes flop 2 ignore its j/k inputs.
    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (!(inject && i == 2)) begin
                case ({j[i], k[i]})
                    2'b01:   bank[i] <= 1'b0;
                    2'b10:   bank[i] <= 1'b1;
                    2'b11:   bank[i] <= ~bank[i];
                    default: ;
                endcase
            end
        end
    end

    function automatic bit opResult(input bit old, input logic [1:0] op);
        case (op)
            2'b00:   return old;
            2'b01:   return 1'b0;
            2'b10:   return 1'b1;
            default: return !old;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input bit use_a, input bit use_b,
                                 input logic [IDXW-1:0] ai, input logic [1:0] ao,
                                 input logic [IDXW-1:0] bi, input logic [1:0] bo);
        a_valid = use_a;
        a_idx   = ai;
        a_op    = ao;
        b_valid = use_b;
        b_idx   = bi;
        b_op    = bo;
    endtask

    task automatic resetDut();
        a_valid = 1'b0;
        b_valid = 1'b0;
        rst     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b1;
        prio_m = 1'b0;
    endtask

    // Waits for one grant and follows that command through to its response.
    task automatic serveOne(input bit keep);
        int              waitc;
        bit              gb;
        bit              in_r;
        bit              old;
        bit              res;
        bit              act;
        logic [IDXW-1:0] ci;
        logic [1:0]      co;
        logic [31:0]     onehot;
        @(negedge clk);
        waitc = 0;
        while (!(a_ready || b_ready) && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        checkOutput("ready_timeout", 32'(waitc < 20), 32'd1);
        if (waitc >= 20) return;
        gb = b_valid && (!a_valid || prio_m);
        checkOutput("grant_a", 32'(a_ready), 32'(!gb));
        checkOutput("grant_b", 32'(b_ready), 32'(gb));
        checkOutput("busy_idle", 32'(busy), 32'd0);
        ci     = gb ? b_idx : a_idx;
        co     = gb ? b_op : a_op;
        in_r   = int'(ci) < N;
        prio_m = !gb;
        onehot = 32'd1 << ci;
        @(posedge clk);
        #1;
        if (!keep) begin
            if (gb) b_valid = 1'b0;
            else    a_valid = 1'b0;
        end
        @(negedge clk);
        checkOutput("ready_when_busy", 32'({a_ready, b_ready}), 32'd0);
        if (in_r) begin
            old = ref_bank[ci];
            res = opResult(old, co);
            act = (inject && ci == 2) ? old : res;
            ref_bank[ci] = act;
            checkOutput("drive_j", 32'(j), co[1] ? onehot : 32'd0);
            checkOutput("drive_k", 32'(k), co[0] ? onehot : 32'd0);
            checkOutput("drive_rsp_valid", 32'(rsp_valid), 32'd0);
            checkOutput("drive_busy", 32'(busy), 32'd1);
            @(negedge clk);
            checkOutput("check_j", 32'(j), 32'd0);
            checkOutput("check_k", 32'(k), 32'd0);
            checkOutput("check_rsp_valid", 32'(rsp_valid), 32'd1);
            checkOutput("check_rsp_src", 32'(rsp_src), 32'(gb));
            checkOutput("check_rsp_q", 32'(rsp_q), 32'(act));
            checkOutput("check_rsp_err", 32'(rsp_err), 32'(act != res));
            checkOutput("check_ready", 32'({a_ready, b_ready}), 32'd0);
        end else begin
            checkOutput("oor_j", 32'(j), 32'd0);
            checkOutput("oor_k", 32'(k), 32'd0);
            checkOutput("oor_rsp_valid", 32'(rsp_valid), 32'd1);
            checkOutput("oor_rsp_src", 32'(rsp_src), 32'(gb));
            checkOutput("oor_rsp_q", 32'(rsp_q), 32'd0);
            checkOutput("oor_rsp_err", 32'(rsp_err), 32'd1);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int gap;
        int mode;
        for (int i = 0; i < N; i++) ref_bank[i] = 1'b0;

        // Reset state, with a request pending that must not be accepted.
        applyStimulus(1, 1, 3'd1, 2'b10, 3'd2, 2'b10);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_a_ready", 32'(a_ready), 32'd0);
        checkOutput("rst_b_ready", 32'(b_ready), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_j", 32'(j), 32'd0);
        checkOutput("rst_k", 32'(k), 32'd0);
        checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("rst_rsp_src", 32'(rsp_src), 32'd0);
        checkOutput("rst_rsp_q", 32'(rsp_q), 32'd0);
        checkOutput("rst_rsp_err", 32'(rsp_err), 32'd0);
        @(posedge clk);
        #1;
        a_valid = 1'b0;
        b_valid = 1'b0;
        rst     = 1'b1;

        $display("[TB] single set on idx 3");
        applyStimulus(1, 0, 3'd3, 2'b10, 3'd0, 2'b00);
        serveOne(0);

        $display("[TB] toggle twice on idx 5, then hold from B");
        applyStimulus(1, 0, 3'd5, 2'b11, 3'd0, 2'b00);
        serveOne(0);
        applyStimulus(1, 0, 3'd5, 2'b11, 3'd0, 2'b00);
        serveOne(0);
        applyStimulus(0, 1, 3'd0, 2'b00, 3'd3, 2'b00);
        serveOne(0);

        $display("[TB] contention with both valids held");
        resetDut();
        applyStimulus(1, 1, 3'd0, 2'b01, 3'd1, 2'b01);
        repeat (4) serveOne(1);
        a_valid = 1'b0;
        b_valid = 1'b0;

        $display("[TB] readback error on idx 2");
        applyStimulus(1, 0, 3'd2, 2'b01, 3'd0, 2'b00);
        serveOne(0);
        inject = 1'b1;
        applyStimulus(1, 0, 3'd2, 2'b10, 3'd0, 2'b00);
        serveOne(0);
        inject = 1'b0;

        $display("[TB] out-of-range indices");
        applyStimulus(0, 1, 3'd0, 2'b00, 3'd7, 2'b10);
        serveOne(0);
        applyStimulus(1, 0, 3'd6, 2'b11, 3'd0, 2'b00);
        serveOne(0);

        $display("[TB] reset during CHECK");
        applyStimulus(1, 0, 3'd1, 2'b10, 3'd0, 2'b00);
        @(negedge clk);
        checkOutput("mid_accept", 32'(a_ready), 32'd1);
        @(posedge clk);
        #1;
        a_valid = 1'b0;
        @(posedge clk);
        #1;
        ref_bank[1] = 1'b1;
        rst = 1'b0;
        applyStimulus(1, 0, 3'd1, 2'b11, 3'd0, 2'b00);
        @(negedge clk);
        checkOutput("mid_check_rsp", 32'(rsp_valid), 32'd1);
        @(posedge clk);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checkOutput("mid_rsp_valid", 32'(rsp_valid), 32'd0);
            checkOutput("mid_busy", 32'(busy), 32'd0);
            checkOutput("mid_jk", 32'({j, k}), 32'd0);
            checkOutput("mid_a_ready", 32'(a_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        rst    = 1'b1;
        prio_m = 1'b0;
        serveOne(0);

        $display("[TB] random commands");
        for (int it = 0; it < 40; it++) begin
            mode = $urandom_range(0, 2);
            applyStimulus(mode != 1, mode != 0,
                          IDXW'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                          IDXW'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
            serveOne(0);
            if (mode == 2) serveOne(0);
            gap = $urandom_range(0, 2);
            if (gap > 0) begin
                repeat (gap) @(posedge clk);
                #1;
            end
        end

        for (int i = 0; i < N; i++) begin
            checkOutput("final_bank", 32'(bank[i]), 32'(ref_bank[i]));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/jk_bank_ctrl.md
# jk_bank_ctrl

Command scheduler for a bank of N JK flip-flops that share one clock. Two requesters, A and B, issue JK operations on one flip-flop at a time. The block arbitrates between them round-robin and drives a single-cycle j/k pulse to the selected flip-flop. It then reads back q, checks it against the expected next state, and returns a response. It sits between control logic and the flop bank and owns the flop j/k inputs exclusively.

## Interface
Parameters:
- N, 8, number of JK flip-flops driven
- IDXW, 3, width of index fields; indices >= N are out of range

Ports:
- clk  in  1  clock, all state updates on posedge
- rst  in  1  reset, synchronous, active-low
- a_valid  in  1  requester A command valid
- a_ready  out  1  requester A command accepted this cycle
- a_idx  in  IDXW  requester A target flip-flop
- a_op  in  2  requester A operation: 00 hold, 01 reset, 10 set, 11 toggle
- b_valid, b_ready, b_idx, b_op  same widths and meanings for requester B
- j  out  N  j inputs to the flop bank
- k  out  N  k inputs to the flop bank
- q  in  N  q outputs from the flop bank
- rsp_valid  out  1  one-cycle response pulse
- rsp_src  out  1  0 = A, 1 = B
- rsp_q  out  1  q of the target flop after the operation
- rsp_err  out  1  readback mismatch or out-of-range index
- busy  out  1  state is not IDLE

## Operation
FSM states and transitions:
- IDLE: accepts a command.
  - Out-of-range index goes to RESP.
  - Otherwise goes to DRIVE.
- DRIVE: j/k pulse on the target flop. Goes to CHECK.
- CHECK: q compared. Goes to IDLE.
- RESP: error-only response. Goes to IDLE.

Arbitration:
- Only in IDLE; a_ready and b_ready are 0 in every other state.
- If one valid is high, that requester is granted.
- If both are high, the requester named by priority pointer `prio` (0 = A) is granted.
- After any grant, `prio` points to the non-granted requester.
- a_ready/b_ready are combinational from state, the valids and prio. At most one is high.
- A transfer occurs when valid && ready. A requester holds valid, idx and op stable until its ready.

On accept:
- Latch src, idx and op.
- Latch q_old = q[idx].
- Compute expected value:
  - hold: q_old
  - reset: 0
  - set: 1
  - toggle: ~q_old

DRIVE (registered outputs):
- j[idx] = op[1], k[idx] = op[0].
- All other j/k bits are 0.
- The flop samples the pulse at the end of DRIVE.
- j/k are all 0 in every other state.

CHECK:
- rsp_valid = 1, rsp_src = src, rsp_q = q[idx].
- rsp_err = (q[idx] != expected).

RESP:
- rsp_valid = 1, rsp_src = src, rsp_q = 0, rsp_err = 1.
- No j/k activity.

Hold operation still runs DRIVE/CHECK with j=k=0 and verifies q is unchanged.

## Timing
Reset (rst sampled 0 at posedge):
- State returns to IDLE and prio = 0.
- j = k = 0, rsp_valid = 0, rsp_src = 0, rsp_q = 0, rsp_err = 0, busy = 0.
- a_ready and b_ready are 0 while rst = 0.

Latency and throughput:
- Accept at edge T0 (end of IDLE cycle).
- The DRIVE cycle runs from T0 to T1; the flop updates at T1.
- The CHECK cycle runs from T1 to T2, with rsp_valid high in that cycle.
- The next accept is possible at T3.
- Result: 3 cycles per command, response 2 cycles after accept.
- The out-of-range path takes 2 cycles.

Boundary cases:
- Simultaneous valids with prio = 0: A is served first, then B.
- A valid that arrives during busy waits; no command is lost or duplicated.
- Reset during DRIVE: the pulse already presented may still act on the flop. No response is issued, and j/k are 0 from the reset edge onward.
- Reset during CHECK or RESP: rsp_valid drops at the reset edge. The in-flight response is discarded.
- idx == N-1 is valid; idx == N is out of range. With defaults N = 8 and IDXW = 3, every index is in range.
- A requester with valid held high continuously is served every second command when the other requester is also valid (no starvation).

## Test plan
- Reset then single A command:
  - Stimulus: reset, then a_op = 10, a_idx = 3 with q[3] = 0.
  - Required: j = 8'h08, k = 0 for exactly one cycle.
  - Required: rsp_valid 2 cycles after accept with rsp_src = 0, rsp_q = 1, rsp_err = 0.
- Toggle twice on idx 5:
  - Required: rsp_q = 1 then 0, rsp_err = 0 both times.
  - Required: k[5] = j[5] = 1 in each DRIVE cycle only.
- Contention:
  - Stimulus: a_valid and b_valid held high with reset ops to idx 0 and 1.
  - Required grant order: A, B, A, B; each ready is high for exactly one cycle per grant.
  - Required: rsp_src alternates 0, 1, 0, 1.
- Error injection:
  - Stimulus: the bench model ignores j/k for set on idx 2.
  - Required: rsp_err = 1, rsp_q = 0.
- Out of range:
  - Stimulus: N = 6, b_idx = 7.
  - Required: no j/k activity; rsp_valid one cycle after accept with rsp_src = 1, rsp_err = 1, rsp_q = 0.
- Reset mid-operation:
  - Stimulus: rst = 0 sampled during CHECK.
  - Required: no rsp_valid after that edge; busy = 0, j = k = 0.
  - Required: the next command after reset release completes normally.
